// File: rtl/cpu_reset_ctrl_if.sv
// Control/status bundle between the reset controller and the board.
// The slave modport is the controller side and the master modport is the board side.
interface cpu_reset_ctrl_if;
    logic BUTTON_N;
    logic CPU_RESET_N;
    logic WDT_KICK;
    logic RESET_OE;
    logic HALT_OE;
    logic PERIPH_RESET;
    logic CPU_RUN;
    logic WDT_FIRED;

    modport master (
        output BUTTON_N, CPU_RESET_N, WDT_KICK,
        input  RESET_OE, HALT_OE, PERIPH_RESET, CPU_RUN, WDT_FIRED
    );

    modport slave (
        input  BUTTON_N, CPU_RESET_N, WDT_KICK,
        output RESET_OE, HALT_OE, PERIPH_RESET, CPU_RUN, WDT_FIRED
    );
endinterface

// File: rtl/cpu_reset_ctrl.sv
// 68000 reset sequencer: minimum-width /RESET+/HALT, debounced button, RESET-instruction pass-through.
// Optional watchdog is built when CPU_RESET_WDT_EN is defined.
module cpu_reset_ctrl #(
    parameter int HOLD_CYCLES     = 100000,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int WDT_CYCLES      = 1000000
) (
    input  logic             MCLK_IN,
    input  logic             RESET_N,
    cpu_reset_ctrl_if.slave  bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_PRST  = 2'd3;

    logic          r_btn_s1, r_btn_s2, r_crst_s1, r_crst_s2;
    logic          r_btn_pressed;
    logic [DW-1:0] r_db_cnt;
    logic [1:0]    r_state;
    logic [HW-1:0] r_count;
    logic          r_reset_oe, r_halt_oe, r_periph_reset, r_cpu_run;

    logic          w_btn_sample, w_btn_next, w_press_evt, w_wdt_timeout;
    logic [DW-1:0] w_db_cnt_next;
    logic [1:0]    w_state_next;
    logic [HW-1:0] w_count_next;

    always_ff @(posedge MCLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_btn_s1  <= 1'b1;
            r_btn_s2  <= 1'b1;
            r_crst_s1 <= 1'b1;
            r_crst_s2 <= 1'b1;
        end else begin
            r_btn_s1  <= bus.BUTTON_N;
            r_btn_s2  <= r_btn_s1;
            r_crst_s1 <= bus.CPU_RESET_N;
            r_crst_s2 <= r_crst_s1;
        end
    end

    // The press event is taken combinationally, so the FSM reacts on the same edge the stable state flips.
    assign w_btn_sample = ~r_btn_s2;
    always_comb begin
        w_btn_next    = r_btn_pressed;
        w_db_cnt_next = '0;
        if (w_btn_sample != r_btn_pressed) begin
            if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1))
                w_btn_next = w_btn_sample;
            else
                w_db_cnt_next = r_db_cnt + 1'b1;
        end
    end
    assign w_press_evt = w_btn_next & ~r_btn_pressed;

`ifdef CPU_RESET_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] r_wdt_cnt, w_wdt_cnt_next;
    logic          r_wdt_fired;

    always_comb begin
        w_wdt_timeout  = 1'b0;
        w_wdt_cnt_next = '0;
        if ((r_state == S_RUN || r_state == S_PRST) && !bus.WDT_KICK) begin
            if (r_wdt_cnt == WW'(WDT_CYCLES - 1))
                w_wdt_timeout = 1'b1;
            else
                w_wdt_cnt_next = r_wdt_cnt + 1'b1;
        end
    end

    always_ff @(posedge MCLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wdt_cnt   <= '0;
            r_wdt_fired <= 1'b0;
        end else begin
            r_wdt_cnt <= w_wdt_cnt_next;
            if (w_wdt_timeout)
                r_wdt_fired <= 1'b1;
        end
    end
    assign bus.WDT_FIRED = r_wdt_fired;
`else
    logic w_unused;
    assign w_unused      = bus.WDT_KICK & (WDT_CYCLES >= 2);
    assign w_wdt_timeout = 1'b0;
    assign bus.WDT_FIRED = 1'b0;
`endif

    // r_count is the HOLD width counter and also times the 3-cycle BLANK window.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_HOLD: begin
                if (w_press_evt) begin
                    w_count_next = '0;
                end else if (r_count >= HW'(HOLD_CYCLES - 1) && !w_btn_next) begin
                    w_state_next = S_BLANK;
                    w_count_next = '0;
                end else if (r_count != HW'(HOLD_CYCLES)) begin
                    w_count_next = r_count + 1'b1;
                end
            end
            S_BLANK: begin
                if (w_press_evt) begin
                    w_state_next = S_HOLD;
                    w_count_next = '0;
                end else if (r_count == HW'(2)) begin
                    w_state_next = S_RUN;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            default: begin
                if (w_press_evt || w_wdt_timeout) begin
                    w_state_next = S_HOLD;
                    w_count_next = '0;
                end else if (r_state == S_RUN && !r_crst_s2) begin
                    w_state_next = S_PRST;
                end else if (r_state == S_PRST && r_crst_s2) begin
                    w_state_next = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge MCLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_btn_pressed  <= 1'b0;
            r_db_cnt       <= '0;
            r_state        <= S_HOLD;
            r_count        <= '0;
            r_reset_oe     <= 1'b1;
            r_halt_oe      <= 1'b1;
            r_periph_reset <= 1'b1;
            r_cpu_run      <= 1'b0;
        end else begin
            r_btn_pressed  <= w_btn_next;
            r_db_cnt       <= w_db_cnt_next;
            r_state        <= w_state_next;
            r_count        <= w_count_next;
            r_reset_oe     <= (w_state_next == S_HOLD);
            r_halt_oe      <= (w_state_next == S_HOLD);
            r_periph_reset <= (w_state_next != S_RUN);
            r_cpu_run      <= (w_state_next == S_RUN) || (w_state_next == S_PRST);
        end
    end

    assign bus.RESET_OE     = r_reset_oe;
    assign bus.HALT_OE      = r_halt_oe;
    assign bus.PERIPH_RESET = r_periph_reset;
    assign bus.CPU_RUN      = r_cpu_run;
endmodule

// File: tb/tb_cpu_reset_ctrl.sv
// Self-checking bench for cpu_reset_ctrl with HOLD=8, DEBOUNCE=4, WDT=20.
// Output vector order: {RESET_OE, HALT_OE, PERIPH_RESET, CPU_RUN, WDT_FIRED}.
module tb_cpu_reset_ctrl;
    localparam logic [4:0] O_HOLD  = 5'b11100;
    localparam logic [4:0] O_BLANK = 5'b00100;
    localparam logic [4:0] O_RUN   = 5'b00010;
    localparam logic [4:0] O_PRST  = 5'b00110;

    typedef struct {
        logic       btn_n;
        logic       crst_n;
        logic       kick;
        int         n;
        logic [4:0] exp;
        string      tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t tbl[$];
    logic [4:0] exp_q[$];

    cpu_reset_ctrl_if bus_if ();

    cpu_reset_ctrl #(
        .HOLD_CYCLES(8),
        .DEBOUNCE_CYCLES(4),
        .WDT_CYCLES(20)
    ) dut (
        .MCLK_IN(clk),
        .RESET_N(rst_n),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {bus_if.RESET_OE, bus_if.HALT_OE, bus_if.PERIPH_RESET, bus_if.CPU_RUN, bus_if.WDT_FIRED};
    endfunction

    task automatic check(input string tag, input logic [4:0] want);
        logic [4:0] got;
        got = outs();
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s (vector %0d): outputs %b, expected %b", tag, n_vec, got, want);
        end
    endtask

    // Entered at a negedge: drive, queue the expectation, compare just after the next posedge.
    task automatic step(input logic b, input logic c, input logic k, input logic [4:0] e, input string tag);
        logic [4:0] want;
        bus_if.BUTTON_N    = b;
        bus_if.CPU_RESET_N = c;
        bus_if.WDT_KICK    = k;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(tag, want);
        @(negedge clk);
    endtask

    task automatic run(input logic b, input logic c, input logic k, input int n, input logic [4:0] e, input string tag);
        for (int i = 0; i < n; i++) step(b, c, k, e, tag);
    endtask

    task automatic add(input logic b, input logic c, input logic k, input int n, input logic [4:0] e, input string tag);
        vec_t v;
        v.btn_n = b; v.crst_n = c; v.kick = k; v.n = n; v.exp = e; v.tag = tag;
        tbl.push_back(v);
    endtask

    initial begin
        // Power-on release: 7 HOLD samples, BLANK on the 8th edge for 3, then RUN.
        add(1, 1, 1, 7,   O_HOLD,  "t1_hold");
        add(1, 1, 1, 3,   O_BLANK, "t1_blank");
        add(1, 1, 1, 5,   O_RUN,   "t1_run");
        // Short 3-cycle press is filtered.
        add(0, 1, 1, 3,   O_RUN,   "t2_short_low");
        add(1, 1, 1, 6,   O_RUN,   "t2_short_high");
        // 6-cycle press: HOLD on the 6th low cycle, then 8-cycle minimum width.
        add(0, 1, 1, 5,   O_RUN,   "t2_press_wait");
        add(0, 1, 1, 1,   O_HOLD,  "t2_press_hold");
        add(1, 1, 1, 7,   O_HOLD,  "t2_hold");
        add(1, 1, 1, 3,   O_BLANK, "t2_blank");
        add(1, 1, 1, 4,   O_RUN,   "t2_run");
        // Button held 50 cycles extends reset; drop 6 cycles after release.
        add(0, 1, 1, 5,   O_RUN,   "t3_press_wait");
        add(0, 1, 1, 45,  O_HOLD,  "t3_held");
        add(1, 1, 1, 5,   O_HOLD,  "t3_release_wait");
        add(1, 1, 1, 3,   O_BLANK, "t3_blank");
        add(1, 1, 1, 4,   O_RUN,   "t3_run");
        // RESET instruction: 124 cycles low.
        add(1, 0, 1, 2,   O_RUN,   "t4_sync");
        add(1, 0, 1, 122, O_PRST,  "t4_prst_low");
        add(1, 1, 1, 2,   O_PRST,  "t4_prst_tail");
        add(1, 1, 1, 3,   O_RUN,   "t4_run");
        // Press event and synced CPU reset on the same edge: button wins.
        add(0, 1, 1, 3,   O_RUN,   "t5_btn");
        add(0, 0, 1, 2,   O_RUN,   "t5_both");
        add(0, 0, 1, 3,   O_HOLD,  "t5_hold_not_prst");
        add(1, 1, 1, 5,   O_HOLD,  "t5_hold");
        add(1, 1, 1, 3,   O_BLANK, "t5_blank");
        add(1, 1, 1, 3,   O_RUN,   "t5_run");

        rst_n = 1'b0;
        bus_if.BUTTON_N    = 1'b1;
        bus_if.CPU_RESET_N = 1'b1;
        bus_if.WDT_KICK    = 1'b0;
        @(negedge clk);
        check("reset_state", O_HOLD);
        @(negedge clk);
        @(negedge clk);
        check("reset_state_clocked", O_HOLD);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i].btn_n, tbl[i].crst_n, tbl[i].kick, tbl[i].n, tbl[i].exp, tbl[i].tag);

        // Press while the CPU is executing RESET: PRST -> HOLD.
        run(1, 0, 1, 2, O_RUN,   "prst_btn_sync");
        run(0, 0, 1, 5, O_PRST,  "prst_btn_wait");
        run(0, 0, 1, 1, O_HOLD,  "prst_btn_hold");
        run(1, 1, 1, 7, O_HOLD,  "prst_btn_hold2");
        run(1, 1, 1, 3, O_BLANK, "prst_btn_blank");
        run(1, 1, 1, 3, O_RUN,   "prst_btn_run");

`ifdef CPU_RESET_WDT_EN
        for (int i = 0; i < 4; i++) begin
            run(1, 1, 0, 14, O_RUN, "wdt_kick15_idle");
            run(1, 1, 1, 1,  O_RUN, "wdt_kick15");
        end
        run(1, 1, 0, 19, O_RUN, "wdt_late_idle");
        run(1, 1, 1, 1,  O_RUN, "wdt_kick_on_timeout");
        run(1, 1, 0, 19, O_RUN, "wdt_starve");
        run(1, 1, 0, 1,  O_HOLD | 5'b00001, "wdt_timeout");
        run(1, 1, 0, 7,  O_HOLD | 5'b00001, "wdt_hold");
        run(1, 1, 0, 3,  O_BLANK | 5'b00001, "wdt_blank");
        run(1, 1, 1, 3,  O_RUN | 5'b00001,  "wdt_sticky");
`else
        run(1, 1, 0, 40, O_RUN, "no_wdt_idle");
`endif

        // Asynchronous reset mid-cycle returns everything to power-on state.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", O_HOLD);
        @(negedge clk);
        check("reset_clears_sticky", O_HOLD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
